// File: rtl/liteeth_sram_fifo_ctrl_if.sv
// liteeth_sram_fifo_ctrl_if: stream and SRAM bus bundle for liteeth_sram_fifo_ctrl.
// Ports: in_valid/in_ready/in_data input stream; out_valid/out_ready/out_data output stream;
// sram_csb0/web0/wmask0/addr0/din0 SRAM port 0 (1RW, write only here); sram_csb1/addr1/dout1 SRAM port 1 (read).
// master = controller side, slave = MAC datapath + SRAM macro side.
interface liteeth_sram_fifo_ctrl_if #(
  parameter int BITS = 32,
  parameter int ADDR_WIDTH = 9
);
  logic in_valid;
  logic in_ready;
  logic [BITS-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [BITS-1:0] out_data;
  logic sram_csb0;
  logic sram_web0;
  logic [3:0] sram_wmask0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [BITS-1:0] sram_din0;
  logic sram_csb1;
  logic [ADDR_WIDTH-1:0] sram_addr1;
  logic [BITS-1:0] sram_dout1;
  modport master (
    input in_valid, in_data, out_ready, sram_dout1,
    output in_ready, out_valid, out_data, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    sram_csb1, sram_addr1
  );
  modport slave (
    output in_valid, in_data, out_ready, sram_dout1,
    input in_ready, out_valid, out_data, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
    sram_csb1, sram_addr1
  );
endinterface

// File: rtl/liteeth_sram_fifo_ctrl.sv
// liteeth_sram_fifo_ctrl: 384-word FIFO built on the dual-port liteeth SRAM with a 2-entry output buffer.
// Ports: sys_clk, sys_rst (sync, active high); bus (master modport): input stream writes SRAM port 0,
// port-1 reads drain into the output stream.
// Optional LITEETH_SRAM_FIFO_LEVEL_EN adds output level = count + inflight + buf_cnt, registered.
module liteeth_sram_fifo_ctrl #(
  parameter int BITS = 32,
  parameter int WORD_DEPTH = 384,
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH = 10
) (
  input logic sys_clk,
  input logic sys_rst,
  liteeth_sram_fifo_ctrl_if.master bus
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
  ,
  output logic [CNT_WIDTH+1:0] level
`endif
);
  localparam int LW = CNT_WIDTH + 2;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic inflight;
  logic [1:0] buf_cnt, after_pop;
  logic [BITS-1:0] b0, b1, b0_nx, b1_nx;
  logic accept, pop, issue;
  function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] p);
    return p == ADDR_WIDTH'(WORD_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign bus.in_ready = count != CNT_WIDTH'(WORD_DEPTH);
  assign accept = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  // a read may only be issued if its data will have a buffer slot when it lands
  assign issue = (count != '0) && (3'(buf_cnt) + 3'(inflight) + 3'd1 <= 3'd2 + 3'(pop));
  assign bus.out_valid = buf_cnt != 2'd0;
  assign bus.out_data = b0;
  assign bus.sram_csb0 = !accept;
  assign bus.sram_web0 = !accept;
  assign bus.sram_wmask0 = 4'hF;
  assign bus.sram_addr0 = wr_ptr;
  assign bus.sram_din0 = accept ? bus.in_data : '0;
  assign bus.sram_csb1 = !issue;
  assign bus.sram_addr1 = rd_ptr;
  // b0 is the head; captured data goes behind whatever survives this cycle's pop
  assign after_pop = buf_cnt - 2'(pop);
  assign b0_nx = inflight && after_pop == 2'd0 ? bus.sram_dout1 : pop ? b1 : b0;
  assign b1_nx = inflight && after_pop != 2'd0 ? bus.sram_dout1 : b1;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      inflight <= 1'b0;
      buf_cnt <= '0;
      b0 <= '0;
      b1 <= '0;
    end else begin
      if (accept) wr_ptr <= nxt(wr_ptr);
      if (issue) rd_ptr <= nxt(rd_ptr);
      count <= count + CNT_WIDTH'(accept) - CNT_WIDTH'(issue);
      inflight <= issue;
      buf_cnt <= after_pop + 2'(inflight);
      b0 <= b0_nx;
      b1 <= b1_nx;
    end
  end
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) level <= '0;
    else level <= LW'(count) + LW'(inflight) + LW'(buf_cnt);
  end
`endif
endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// tb_liteeth_sram_fifo_ctrl: vector table, directed corner sequences and randomized traffic against a counting model.
module tb_liteeth_sram_fifo_ctrl;
  localparam int BITS = 32, DEPTH = 384, AW = 9, CW = 10;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;
  liteeth_sram_fifo_ctrl_if #(.BITS(BITS), .ADDR_WIDTH(AW)) bus ();
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
  logic [CW+1:0] level;
`endif
  liteeth_sram_fifo_ctrl #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    ,
    .level(level)
`endif
  );
  logic [BITS-1:0] mem [DEPTH];
  always @(posedge sys_clk) begin
    if (!bus.sram_csb0 && !bus.sram_web0 && int'(bus.sram_addr0) < DEPTH) mem[bus.sram_addr0] <= bus.sram_din0;
    if (!bus.sram_csb1 && int'(bus.sram_addr1) < DEPTH) bus.sram_dout1 <= mem[bus.sram_addr1];
  end
  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  logic [BITS-1:0] q[$];
  int wr_n, rd_n, pop_n, cap_n, last_pop, max_gap;
  bit infl_m, acc, iss, pp, exp_iss;
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      q.delete();
      wr_n = 0;
      rd_n = 0;
      pop_n = 0;
      cap_n = 0;
      infl_m = 0;
    end else begin
      acc = bus.in_valid && bus.in_ready;
      pp = bus.out_valid && bus.out_ready;
      iss = !bus.sram_csb1;
      chk("in_ready", bus.in_ready, (wr_n - rd_n) != DEPTH);
      chk("out_valid", bus.out_valid, cap_n != pop_n);
      exp_iss = (wr_n != rd_n) && (rd_n - pop_n + 1 <= 2 + int'(pp));
      chk("issue", iss, exp_iss);
      chk("csb0", bus.sram_csb0, !acc);
      chk("web0", bus.sram_web0, !acc);
      chk("wmask0", bus.sram_wmask0, 4'hF);
      if (acc) begin
        chk("addr0", bus.sram_addr0, wr_n % DEPTH);
        chk("din0", bus.sram_din0, bus.in_data);
        q.push_back(bus.in_data);
        wr_n++;
      end
      if (iss) begin
        chk("addr1", bus.sram_addr1, rd_n % DEPTH);
        rd_n++;
      end
      if (pp) begin
        if (q.size() == 0) chk("pop_empty", 1, 0);
        else chk("out_data", bus.out_data, q.pop_front());
        pop_n++;
        if (last_pop >= 0 && cyc - last_pop > max_gap) max_gap = cyc - last_pop;
        last_pop = cyc;
      end
      cap_n += int'(infl_m);
      infl_m = iss;
    end
  end
  typedef struct {
    bit iv;
    logic [31:0] d;
    bit ordy;
    bit e_rdy;
    bit e_csb0;
    int e_a0;
    bit e_csb1;
    int e_a1;
    bit e_ov;
    logic [31:0] e_od;
  } vec_t;
  vec_t tbl[6];
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic push_words(input int n, input logic [31:0] base, input int idle_pct, input bit rnd);
    bit ok;
    for (int k = 0; k < n; k++) begin
      if (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct) begin
        bus.in_valid = 1'b0;
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data = rnd ? $urandom : base + k;
      ok = 0;
      for (int t = 0; t < 2000 && !ok; t++) begin
        @(negedge sys_clk);
        ok = bus.in_ready;
        step();
      end
      if (!ok) chk("push_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic drain(input string nm);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 3000 && pop_n != wr_n; t++) step();
    chk(nm, pop_n, wr_n);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  bit done, ok;
  int n;
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    last_pop = -1;
    max_gap = 0;
    tbl[0] = '{1, 32'hDEADBEEF, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 32'h12345678, 1, 1, 0, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 1, 1, 0, 0, 1, 0, 0};
    tbl[3] = '{0, 0, 1, 1, 1, 0, 1, 0, 1, 32'hDEADBEEF};
    tbl[4] = '{0, 0, 1, 1, 1, 0, 1, 0, 1, 32'h12345678};
    tbl[5] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 0};
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_csb0", bus.sram_csb0, 1);
    chk("rst_web0", bus.sram_web0, 1);
    chk("rst_csb1", bus.sram_csb1, 1);
    chk("rst_wmask0", bus.sram_wmask0, 4'hF);
    chk("rst_addr0", bus.sram_addr0, 0);
    chk("rst_addr1", bus.sram_addr1, 0);
    chk("rst_din0", bus.sram_din0, 0);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    chk("rst_level", level, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      bus.in_valid = tbl[i].iv;
      bus.in_data = tbl[i].d;
      bus.out_ready = tbl[i].ordy;
      @(negedge sys_clk);
      chk("v_in_ready", bus.in_ready, tbl[i].e_rdy);
      chk("v_csb0", bus.sram_csb0, tbl[i].e_csb0);
      if (!tbl[i].e_csb0) chk("v_addr0", bus.sram_addr0, tbl[i].e_a0);
      chk("v_csb1", bus.sram_csb1, tbl[i].e_csb1);
      if (!tbl[i].e_csb1) chk("v_addr1", bus.sram_addr1, tbl[i].e_a1);
      chk("v_out_valid", bus.out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) chk("v_out_data", bus.out_data, tbl[i].e_od);
    end
    step();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    bus.in_data = 32'hF000_0000;
    for (int c = 0; c < 800 && n < 386; c++) begin
      @(negedge sys_clk);
      ok = bus.in_ready;
      step();
      if (ok) begin
        n++;
        bus.in_data = 32'hF000_0000 + n;
      end
    end
    chk("full_accepts", n, 386);
    repeat (5) begin
      @(negedge sys_clk);
      chk("full_in_ready", bus.in_ready, 0);
      chk("full_csb0", bus.sram_csb0, 1);
      chk("full_out_valid", bus.out_valid, 1);
      step();
    end
    bus.in_valid = 1'b0;
    drain("full_drain");
    last_pop = -1;
    max_gap = 0;
    push_words(1000, 32'h0, 0, 0);
    drain("stream_drain");
    chk("stream_gap", max_gap, 1);
    done = 0;
    fork
      begin
        push_words(2000, 32'h0, 40, 1);
        done = 1;
      end
      begin
        while (!done) begin
          bus.out_ready = $urandom_range(0, 1) == 1;
          step();
        end
      end
    join
    drain("random_drain");
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hAAAA5555;
    step();
    bus.in_valid = 1'b0;
    ok = 0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge sys_clk);
      ok = !bus.sram_csb1;
    end
    chk("mid_issue_seen", ok, 1);
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      chk("mid_out_valid", bus.out_valid, 0);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
      chk("mid_level", level, 0);
`endif
    end
    step();
    bus.in_valid = 1'b1;
    bus.in_data = 32'h0000_0001;
    @(negedge sys_clk);
    chk("mid_csb0", bus.sram_csb0, 0);
    chk("mid_addr0", bus.sram_addr0, 0);
    step();
    bus.in_valid = 1'b0;
    @(negedge sys_clk);
    chk("mid_lat1", bus.out_valid, 0);
    @(negedge sys_clk);
    chk("mid_lat2", bus.out_valid, 0);
    @(negedge sys_clk);
    chk("mid_lat3", bus.out_valid, 1);
    chk("mid_data", bus.out_data, 32'h0000_0001);
    step();
    @(negedge sys_clk);
    chk("mid_empty", bus.out_valid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
